// File: rtl/div_arbiter.sv
// Shares one fixed-latency pipelined divider between two lanes, issuing round-robin with a tag pipeline.
// Latency: request accept to rsp_valid is LATENCY+1 cycles; one issue per cycle at most.
// Backpressure: each lane holds one result until rsp_ready; a lane with an op in flight or buffered is not granted.
module div_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_signed,
    input  logic [WIDTH-1:0] req_numer0,
    input  logic [WIDTH-1:0] req_numer1,
    input  logic [WIDTH-1:0] req_denom0,
    input  logic [WIDTH-1:0] req_denom1,
    output logic [1:0]       req_ready,
    output logic             div_start,
    output logic             div_signed,
    output logic [WIDTH-1:0] div_numer,
    output logic [WIDTH-1:0] div_denom,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient0,
    output logic [WIDTH-1:0] rsp_quotient1,
    output logic [WIDTH-1:0] rsp_remainder0,
    output logic [WIDTH-1:0] rsp_remainder1,
    output logic [1:0]       rsp_by_zero
);

    // One entry per in-flight divide; numer is kept so a divide-by-zero can return it as the remainder.
    typedef struct packed {
        logic             vld;
        logic             lane;
        logic             by_zero;
        logic [WIDTH-1:0] numer;
    } tag_t;

    tag_t             tag_pipe [LATENCY];
    tag_t             issue_tag;
    tag_t             done_tag;
    logic             last_grant;
    logic [1:0]       busy;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [WIDTH-1:0] cmp_quotient;
    logic [WIDTH-1:0] cmp_remainder;

    // A lane is busy while its op is anywhere in the tag pipeline or its result slot is occupied.
    always_comb begin
        busy = rsp_valid;
        for (int s = 0; s < LATENCY; s++) begin
            if (tag_pipe[s].vld) begin
                busy[tag_pipe[s].lane] = 1'b1;
            end
        end
    end

    // Round-robin grant: on a tie the lane that did not win last time goes first.
    always_comb begin
        elig      = req_valid & ~busy & {2{~flush}};
        grant[0]  = elig[0] && (!elig[1] || last_grant);
        grant[1]  = elig[1] && (!elig[0] || !last_grant);
        req_ready = grant;
        div_start = |grant;
        // Lane 0 operands are presented whenever lane 1 is not granted, including idle cycles.
        div_signed = grant[1] ? req_signed[1] : req_signed[0];
        div_numer  = grant[1] ? req_numer1    : req_numer0;
        div_denom  = grant[1] ? req_denom1    : req_denom0;
    end

    // Build the tag for this cycle's issue and pick out the completing tag with its final result.
    always_comb begin
        issue_tag.vld     = div_start;
        issue_tag.lane    = grant[1];
        issue_tag.by_zero = (div_denom == '0);
        issue_tag.numer   = div_numer;
        done_tag          = tag_pipe[LATENCY-1];
        // Divide-by-zero never trusts the divider: all-ones quotient, numerator as remainder.
        cmp_quotient      = done_tag.by_zero ? '1             : div_quotient;
        cmp_remainder     = done_tag.by_zero ? done_tag.numer : div_remainder;
    end

    // Remember which lane won the last issue; flush and idle cycles leave it unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (div_start) begin
            last_grant <= grant[1];
        end
    end

    // Tag shift register mirroring the divider pipeline; flush drops every in-flight op.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int s = 1; s < LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    // Per-lane result slots: capture on completion, release on handshake, drop on flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid      <= 2'b00;
            rsp_by_zero    <= 2'b00;
            rsp_quotient0  <= '0;
            rsp_quotient1  <= '0;
            rsp_remainder0 <= '0;
            rsp_remainder1 <= '0;
        end else if (flush) begin
            rsp_valid <= 2'b00;
        end else begin
            // Completion and pop on the same lane cannot coincide since a busy lane never issues.
            rsp_valid <= rsp_valid & ~rsp_ready;
            if (done_tag.vld && !done_tag.lane) begin
                rsp_valid[0]   <= 1'b1;
                rsp_by_zero[0] <= done_tag.by_zero;
                rsp_quotient0  <= cmp_quotient;
                rsp_remainder0 <= cmp_remainder;
            end
            if (done_tag.vld && done_tag.lane) begin
                rsp_valid[1]   <= 1'b1;
                rsp_by_zero[1] <= done_tag.by_zero;
                rsp_quotient1  <= cmp_quotient;
                rsp_remainder1 <= cmp_remainder;
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a two-stage divider model.
// Inputs are driven 1ns after the rising edge, outputs are sampled 6ns after it.
// Zero denominators make the model emit 0xDEAD/0xBEEF, which must never reach a response.
module tb_div_arbiter;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 2;

    logic             clock;
    logic             reset;
    logic             flush;
    logic [1:0]       req_valid;
    logic [1:0]       req_signed;
    logic [WIDTH-1:0] req_numer0;
    logic [WIDTH-1:0] req_numer1;
    logic [WIDTH-1:0] req_denom0;
    logic [WIDTH-1:0] req_denom1;
    logic [1:0]       req_ready;
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] div_numer;
    logic [WIDTH-1:0] div_denom;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_quotient0;
    logic [WIDTH-1:0] rsp_quotient1;
    logic [WIDTH-1:0] rsp_remainder0;
    logic [WIDTH-1:0] rsp_remainder1;
    logic [1:0]       rsp_by_zero;

    int checks = 0;
    int errors = 0;

    div_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_signed     (req_signed),
        .req_numer0     (req_numer0),
        .req_numer1     (req_numer1),
        .req_denom0     (req_denom0),
        .req_denom1     (req_denom1),
        .req_ready      (req_ready),
        .div_start      (div_start),
        .div_signed     (div_signed),
        .div_numer      (div_numer),
        .div_denom      (div_denom),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_quotient0  (rsp_quotient0),
        .rsp_quotient1  (rsp_quotient1),
        .rsp_remainder0 (rsp_remainder0),
        .rsp_remainder1 (rsp_remainder1),
        .rsp_by_zero    (rsp_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divider model: results for an issue in cycle T are presented during cycle T+2.
    logic [WIDTH-1:0] p1_q = '0, p1_r = '0, p2_q = '0, p2_r = '0;

    function automatic logic [2*WIDTH-1:0] div_model(input logic s, input logic [WIDTH-1:0] n,
                                                     input logic [WIDTH-1:0] d);
        logic signed [WIDTH-1:0] sn, sd, sq, sr;
        if (d == '0) return {32'h0000DEAD, 32'h0000BEEF};
        if (s) begin
            sn = n;
            sd = d;
            sq = sn / sd;
            sr = sn % sd;
            return {sq, sr};
        end
        return {n / d, n % d};
    endfunction

    always @(posedge clock) begin
        if (div_start) {p1_q, p1_r} <= div_model(div_signed, div_numer, div_denom);
        p2_q <= p1_q;
        p2_r <= p1_r;
    end
    assign div_quotient  = p2_q;
    assign div_remainder = p2_r;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Ends with reset released at posedge+1; that cycle is cycle 0 for the caller.
    task automatic do_reset();
        reset      = 1'b1;
        flush      = 1'b0;
        req_valid  = 2'b00;
        req_signed = 2'b00;
        rsp_ready  = 2'b00;
        req_numer0 = '0;
        req_numer1 = '0;
        req_denom0 = '0;
        req_denom1 = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #5;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got %b want 0", div_start); end
        checks++; if (rsp_quotient0 !== 32'h0) begin errors++; $display("FAIL reset_q0 got %h want 0", rsp_quotient0); end
        checks++; if (rsp_remainder1 !== 32'h0) begin errors++; $display("FAIL reset_r1 got %h want 0", rsp_remainder1); end
        checks++; if (rsp_by_zero !== 2'b00) begin errors++; $display("FAIL reset_by_zero got %b want 00", rsp_by_zero); end
    endtask

    task automatic test_basic();
        do_reset();
        rsp_ready  = 2'b01;
        req_valid  = 2'b01;
        req_signed = 2'b01;
        req_numer0 = 32'd7;
        req_denom0 = 32'd2;
        #5;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL basic_ready got %b want 01", req_ready); end
        checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL basic_start got %b want 1", div_start); end
        checks++; if (div_numer !== 32'd7) begin errors++; $display("FAIL basic_numer got %h want 7", div_numer); end
        checks++; if (div_denom !== 32'd2) begin errors++; $display("FAIL basic_denom got %h want 2", div_denom); end
        checks++; if (div_signed !== 1'b1) begin errors++; $display("FAIL basic_signed got %b want 1", div_signed); end
        cyc();
        req_valid = 2'b00;
        for (int c = 1; c <= 2; c++) begin
            if (c > 1) cyc();
            #5;
            checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL basic_early_c%0d got %b want 00", c, rsp_valid); end
        end
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL basic_valid got %b want 01", rsp_valid); end
        checks++; if (rsp_quotient0 !== 32'd3) begin errors++; $display("FAIL basic_q got %h want 3", rsp_quotient0); end
        checks++; if (rsp_remainder0 !== 32'd1) begin errors++; $display("FAIL basic_r got %h want 1", rsp_remainder0); end
        checks++; if (rsp_by_zero[0] !== 1'b0) begin errors++; $display("FAIL basic_bz got %b want 0", rsp_by_zero[0]); end
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL basic_pop got %b want 00", rsp_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp_ready  = 2'b11;
        req_valid  = 2'b11;
        req_signed = 2'b10;
        req_numer0 = 32'd100;
        req_denom0 = 32'd7;
        req_numer1 = 32'hFFFF_FFF9;
        req_denom1 = 32'd2;
        #5;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first got %b want 01", req_ready); end
        checks++; if (div_numer !== 32'd100) begin errors++; $display("FAIL rr_first_numer got %h want 64", div_numer); end
        cyc();
        req_valid = 2'b10;
        #5;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second got %b want 10", req_ready); end
        checks++; if (div_numer !== 32'hFFFF_FFF9) begin errors++; $display("FAIL rr_second_numer got %h want fffffff9", div_numer); end
        checks++; if (div_signed !== 1'b1) begin errors++; $display("FAIL rr_second_signed got %b want 1", div_signed); end
        cyc();
        req_valid = 2'b00;
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rr_rsp0_valid got %b want 01", rsp_valid); end
        checks++; if (rsp_quotient0 !== 32'd14) begin errors++; $display("FAIL rr_q0 got %h want e", rsp_quotient0); end
        checks++; if (rsp_remainder0 !== 32'd2) begin errors++; $display("FAIL rr_r0 got %h want 2", rsp_remainder0); end
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rr_rsp1_valid got %b want 10", rsp_valid); end
        checks++; if (rsp_quotient1 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL rr_q1 got %h want fffffffd", rsp_quotient1); end
        checks++; if (rsp_remainder1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rr_r1 got %h want ffffffff", rsp_remainder1); end
        cyc();
        req_valid = 2'b11;
        #5;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_tie2 got %b want 01", req_ready); end
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
        cyc();
        req_valid = 2'b11;
        #5;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_tie3 got %b want 10", req_ready); end
        cyc();
        req_valid = 2'b00;
        for (int c = 0; c < 4; c++) cyc();
    endtask

    task automatic test_by_zero();
        do_reset();
        rsp_ready  = 2'b11;
        req_valid  = 2'b10;
        req_signed = 2'b01;
        req_numer1 = 32'h1234;
        req_denom1 = 32'h0;
        #5;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bz_ready1 got %b want 10", req_ready); end
        checks++; if (div_signed !== 1'b0) begin errors++; $display("FAIL bz_signed1 got %b want 0", div_signed); end
        cyc();
        req_valid  = 2'b01;
        req_numer0 = 32'hFFFF_FFFB;
        req_denom0 = 32'h0;
        #5;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bz_ready0 got %b want 01", req_ready); end
        cyc();
        req_valid = 2'b00;
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bz_valid1 got %b want 10", rsp_valid); end
        checks++; if (rsp_quotient1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bz_q1 got %h want ffffffff", rsp_quotient1); end
        checks++; if (rsp_remainder1 !== 32'h1234) begin errors++; $display("FAIL bz_r1 got %h want 1234", rsp_remainder1); end
        checks++; if (rsp_by_zero !== 2'b10) begin errors++; $display("FAIL bz_flag1 got %b want 10", rsp_by_zero); end
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bz_valid0 got %b want 01", rsp_valid); end
        checks++; if (rsp_quotient0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bz_q0 got %h want ffffffff", rsp_quotient0); end
        checks++; if (rsp_remainder0 !== 32'hFFFF_FFFB) begin errors++; $display("FAIL bz_r0 got %h want fffffffb", rsp_remainder0); end
        checks++; if (rsp_by_zero[0] !== 1'b1) begin errors++; $display("FAIL bz_flag0 got %b want 1", rsp_by_zero[0]); end
        cyc();
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready  = 2'b00;
        req_valid  = 2'b01;
        req_numer0 = 32'd50;
        req_denom0 = 32'd7;
        #5;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept got %b want 01", req_ready); end
        cyc();
        cyc();
        for (int c = 3; c <= 7; c++) begin
            cyc();
            #5;
            checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_hold_valid_c%0d got %b want 01", c, rsp_valid); end
            checks++; if (rsp_quotient0 !== 32'd7) begin errors++; $display("FAIL bp_hold_q_c%0d got %h want 7", c, rsp_quotient0); end
            checks++; if (rsp_remainder0 !== 32'd1) begin errors++; $display("FAIL bp_hold_r_c%0d got %h want 1", c, rsp_remainder0); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold_ready_c%0d got %b want 00", c, req_ready); end
        end
        cyc();
        rsp_ready = 2'b01;
        #5;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_pop_valid got %b want 01", rsp_valid); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_pop_ready got %b want 00", req_ready); end
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_after_valid got %b want 00", rsp_valid); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_after_ready got %b want 01", req_ready); end
        checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL bp_after_start got %b want 1", div_start); end
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_reissue_valid got %b want 01", rsp_valid); end
        checks++; if (rsp_quotient0 !== 32'd7) begin errors++; $display("FAIL bp_reissue_q got %h want 7", rsp_quotient0); end
        cyc();
    endtask

    task automatic test_flush();
        do_reset();
        rsp_ready  = 2'b11;
        req_valid  = 2'b01;
        req_numer0 = 32'd9;
        req_denom0 = 32'd3;
        #5;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fl_accept got %b want 01", req_ready); end
        cyc();
        flush      = 1'b1;
        req_numer0 = 32'd20;
        req_denom0 = 32'd6;
        #5;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL fl_ready got %b want 00", req_ready); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL fl_start got %b want 0", div_start); end
        cyc();
        flush = 1'b0;
        #5;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fl_new_accept got %b want 01", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL fl_valid_c2 got %b want 00", rsp_valid); end
        cyc();
        req_valid = 2'b00;
        #5;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL fl_valid_c3 got %b want 00", rsp_valid); end
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL fl_valid_c4 got %b want 00", rsp_valid); end
        cyc();
        #5;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL fl_new_valid got %b want 01", rsp_valid); end
        checks++; if (rsp_quotient0 !== 32'd3) begin errors++; $display("FAIL fl_new_q got %h want 3", rsp_quotient0); end
        checks++; if (rsp_remainder0 !== 32'd2) begin errors++; $display("FAIL fl_new_r got %h want 2", rsp_remainder0); end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready  = 2'b11;
        req_valid  = 2'b11;
        req_numer0 = 32'd40;
        req_denom0 = 32'd5;
        req_numer1 = 32'd30;
        req_denom1 = 32'd4;
        #5;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_accept got %b want 01", req_ready); end
        cyc();
        reset     = 1'b1;
        req_valid = 2'b00;
        #5;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_valid_c1 got %b want 00", rsp_valid); end
        for (int c = 2; c <= 6; c++) begin
            cyc();
            reset = 1'b0;
            #5;
            checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_valid_c%0d got %b want 00", c, rsp_valid); end
        end
        cyc();
        req_valid = 2'b11;
        #5;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_tie got %b want 01", req_ready); end
        cyc();
        req_valid = 2'b00;
        for (int c = 0; c < 4; c++) cyc();
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        req_valid  = 2'b00;
        req_signed = 2'b00;
        rsp_ready  = 2'b00;
        req_numer0 = '0;
        req_numer1 = '0;
        req_denom0 = '0;
        req_denom1 = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_by_zero();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one pipelined divide unit, with fixed latency, between two requesters (lane 0, lane 1) in the execute stage.
- Arbitrates issue round-robin and tracks in-flight operations with a tag pipeline.
- Handles divide-by-zero without using the divider result, and buffers one result per requester until that requester accepts it.

Parameters:
- WIDTH, 32, operand/result width.
- LATENCY, 2, cycles from div_start to valid div_quotient/div_remainder (>=1).

Ports:
- clock  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discard all in-flight and buffered results
- req_valid  in  2  per-lane request
- req_signed  in  2  per-lane signed (1) / unsigned (0) divide
- req_numer0, req_numer1  in  WIDTH  numerators
- req_denom0, req_denom1  in  WIDTH  denominators
- req_ready  out  2  per-lane accept (combinational)
- div_start  out  1  issue strobe to divider
- div_signed  out  1  issued signedness
- div_numer, div_denom  out  WIDTH  issued operands
- div_quotient, div_remainder  in  WIDTH  divider outputs, valid LATENCY cycles after issue
- rsp_valid  out  2  per-lane result held
- rsp_ready  in  2  per-lane result consume
- rsp_quotient0, rsp_quotient1  out  WIDTH  quotients
- rsp_remainder0, rsp_remainder1  out  WIDTH  remainders
- rsp_by_zero  out  2  denominator was zero

Behaviour:

Reset:
- Asynchronous reset clears tag pipeline valids, slot valids, rsp_valid=0, rsp_* data=0 and last_grant=1, so lane 0 wins the first tie.

Eligibility and grant:
- busy_i = tag in flight for lane i OR slot_i valid. busy_i is derived from registered state only.
- eligible_i = req_valid[i] && !busy_i && !flush.
- Grant rules:
  - Only one lane eligible: grant that lane.
  - Both eligible: grant !last_grant.
- req_ready[i] = grant_i.
- At most one issue per cycle. At most one op per lane in flight or buffered.

Issue (cycle T, grant to lane g):
- div_start=1; div_numer/div_denom/div_signed are lane g operands, combinational.
- last_grant<=g.
- Tag {valid, lane=g, by_zero=(denom==0), numer} enters a LATENCY-deep shift register.
- When nothing is granted, div_start=0 and the divider operands are don't-care (drive lane 0 operands).

Completion:
- The tag reaches the pipeline end in cycle T+LATENCY. In that cycle div_quotient/div_remainder are sampled into slot[lane].
- rsp_valid[lane]=1 from cycle T+LATENCY+1. Total latency request-accept to rsp_valid is LATENCY+1.
- by_zero=1:
  - quotient = all ones; remainder = tag numer.
  - Divider outputs are ignored.
  - Applies to signed and unsigned alike.
- Signed MIN/-1: divider result is passed unchanged; by_zero=0.

Response handshake:
- A slot stays valid with stable data while rsp_ready=0.
- rsp_valid && rsp_ready clears it at the edge.
- Lane becomes eligible again the following cycle; no same-cycle pop-and-issue.

Flush:
- In the flush cycle, req_ready=0 and div_start=0.
- At the edge, all tag valids and slot valids clear. last_grant is kept.
- Divider outputs for flushed ops arrive with no valid tag and are ignored.

Simultaneous events:
- Completion for lane i and pop of lane i cannot coincide, because busy_i prevents a second op.
- Completion of one lane and issue to the other in the same cycle are independent.

Reset mid-operation:
- All in-flight work is dropped; no rsp_valid results from pre-reset issues.

Test Plan:
- Bench divider model has LATENCY=2.
- Lane 0 signed 7/2 accepted cycle 0 -> div_start cycle 0 with numer=7, denom=2; rsp_valid[0]=1 from cycle 3; q=3, r=1, by_zero=0.
- Both lanes request at cycle 0 after reset, rsp_ready=11 -> lane 0 granted cycle 0, lane 1 granted cycle 1. Fresh simultaneous requests after both pop -> lane 0 again, since last_grant=1. Next tie -> lane 1.
- Lane 1 unsigned 0x1234/0 -> rsp_quotient1=0xFFFFFFFF, rsp_remainder1=0x1234, rsp_by_zero[1]=1. Bench divider outputs 0xDEAD/0xBEEF, which must not appear.
- Lane 0 result with rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and data stable, req_ready[0]=0 despite req_valid[0]=1. Assert rsp_ready[0] at cycle k -> req_ready[0]=1 at cycle k+1.
- Issue lane 0 at cycle 0, flush at cycle 1 -> no rsp_valid ever for that op; a new lane 0 request is accepted at cycle 2 and completes normally.
- Issue both lanes, assert reset at cycle 1 -> rsp_valid=00 immediately and stays 00 through cycle 6. The first post-reset tie goes to lane 0.
